// File: rtl/dsram_pkg.sv
// dsram_pkg: shared widths, size encodings, queue entry type and strobe merge for the data-side responder
package dsram_pkg;
  localparam int DATA_W  = 32;
  localparam int ADDR_W  = 32;
  localparam int TIMER_W = 8;
  localparam logic [1:0] SIZE_B = 2'd0;
  localparam logic [1:0] SIZE_H = 2'd1;
  localparam logic [1:0] SIZE_W = 2'd2;
  typedef struct packed {
    logic              is_load;
    logic [DATA_W-1:0] word;
    logic [TIMER_W-1:0] timer;
  } dsram_entry_t;
  function automatic logic [DATA_W-1:0] strb_merge(input logic [DATA_W-1:0] old,
                                                   input logic [DATA_W-1:0] wdata,
                                                   input logic [3:0] wstrb);
    strb_merge = old;
    for (int i = 0; i < 4; i++) strb_merge[8*i +: 8] = wstrb[i] ? wdata[8*i +: 8] : old[8*i +: 8];
  endfunction
endpackage

// File: rtl/resp_fifo.sv
// resp_fifo: circular FIFO of dsram_entry_t with per-entry countdown timers
// ports: clk/reset, i_push+i_entry write, i_pop retire head, o_head, o_full, o_empty
module resp_fifo
  import dsram_pkg::*;
#(
  parameter int QDEPTH = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         i_push,
  input  dsram_entry_t i_entry,
  input  logic         i_pop,
  output dsram_entry_t o_head,
  output logic         o_full,
  output logic         o_empty
);
  localparam int PW = QDEPTH > 1 ? $clog2(QDEPTH) : 1;
  dsram_entry_t r_q [2**PW];
  logic [PW-1:0] r_wp, r_rp;
  logic [PW:0] r_cnt;
  logic w_push, w_pop;
  assign o_full  = r_cnt == (PW+1)'(QDEPTH);
  assign o_empty = r_cnt == '0;
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;
  assign o_head  = r_q[r_rp];
  always_ff @(posedge clk)
    if (reset) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
    end else begin
      r_wp  <= r_wp + PW'(w_push);
      r_rp  <= r_rp + PW'(w_pop);
      r_cnt <= r_cnt + (PW+1)'(w_push) - (PW+1)'(w_pop);
    end
  // timers of stale slots also count down; they are overwritten on the next push
  always_ff @(posedge clk)
    for (int i = 0; i < 2**PW; i++)
      if (w_push && PW'(i) == r_wp) r_q[i] <= i_entry;
      else if (r_q[i].timer != '0) r_q[i].timer <= r_q[i].timer - 1'b1;
endmodule

// File: rtl/dsram_like_resp.sv
// dsram_like_resp: SRAM-like data memory slave with req/addr_ok/data_ok handshake and fixed-latency in-order responses
// ports: req/wr/size/wstrb/addr/wdata request, addr_block stall hook, addr_ok accept, data_ok/rdata registered response
module dsram_like_resp
  import dsram_pkg::*;
#(
  parameter int DEPTH_LOG2 = 10,
  parameter int LATENCY    = 2,
  parameter int QDEPTH     = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req,
  input  logic              wr,
  input  logic [1:0]        size,
  input  logic [3:0]        wstrb,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              addr_block,
  output logic              addr_ok,
  output logic              data_ok,
  output logic [DATA_W-1:0] rdata
);
  // with LATENCY 1 the output register alone supplies the delay, so requests skip the queue
  localparam logic BYP = LATENCY == 1;
  logic [DATA_W-1:0] r_mem [2**DEPTH_LOG2];
  logic [DEPTH_LOG2-1:0] w_idx;
  logic w_acc, w_full, w_empty, w_pop, w_unused;
  dsram_entry_t w_entry, w_head;
  assign w_idx    = addr[DEPTH_LOG2+1:2];
  assign addr_ok  = !w_full && !addr_block;
  assign w_acc    = req && addr_ok;
  assign w_entry  = '{is_load: !wr, word: r_mem[w_idx], timer: TIMER_W'(LATENCY-1)};
  // head leaves one cycle early because the output register adds the final cycle
  assign w_pop    = !w_empty && w_head.timer <= TIMER_W'(1);
  assign w_unused = &{1'b0, size, addr[ADDR_W-1:DEPTH_LOG2+2], addr[1:0]};
  resp_fifo #(.QDEPTH(QDEPTH)) u_fifo (
    .clk    (clk),
    .reset  (reset),
    .i_push (w_acc && !BYP),
    .i_entry(w_entry),
    .i_pop  (w_pop),
    .o_head (w_head),
    .o_full (w_full),
    .o_empty(w_empty)
  );
  always_ff @(posedge clk)
    if (w_acc && wr) r_mem[w_idx] <= strb_merge(r_mem[w_idx], wdata, wstrb);
  always_ff @(posedge clk)
    if (reset) begin
      data_ok <= 1'b0;
      rdata   <= '0;
    end else begin
      data_ok <= BYP ? w_acc : w_pop;
      rdata   <= BYP ? (w_acc && !wr ? r_mem[w_idx] : '0) : (w_pop && w_head.is_load ? w_head.word : '0);
    end
endmodule

// File: tb/tb_dsram_like_resp.sv
// tb_dsram_like_resp: scoreboard bench driving LATENCY 2 and LATENCY 4 responders with identical directed vectors
module tb_dsram_like_resp;
  logic clk = 0, reset = 1, req = 0, wr = 0, addr_block = 0;
  logic [1:0] size = 2'd2;
  logic [3:0] wstrb = 0;
  logic [31:0] addr = 0, wdata = 0;
  logic ok2, dok2, ok4, dok4;
  logic [31:0] rd2, rd4;
  int cyc = 0, tests = 0, fails = 0;
  typedef struct { logic [31:0] d; int c; } exp_t;
  exp_t q2[$], q4[$];
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  dsram_like_resp #(.DEPTH_LOG2(10), .LATENCY(2), .QDEPTH(4)) u2 (
    .clk(clk), .reset(reset), .req(req), .wr(wr), .size(size), .wstrb(wstrb), .addr(addr),
    .wdata(wdata), .addr_block(addr_block), .addr_ok(ok2), .data_ok(dok2), .rdata(rd2));
  dsram_like_resp #(.DEPTH_LOG2(10), .LATENCY(4), .QDEPTH(4)) u4 (
    .clk(clk), .reset(reset), .req(req), .wr(wr), .size(size), .wstrb(wstrb), .addr(addr),
    .wdata(wdata), .addr_block(addr_block), .addr_ok(ok4), .data_ok(dok4), .rdata(rd4));
  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", n, act, exp, cyc);
    end
  endtask
  task automatic mon(input string n, input logic dok, input logic [31:0] rd, ref exp_t q[$]);
    if (q.size() > 0 && q[0].c < cyc) begin
      chk({n, " response late"}, cyc, q[0].c);
      void'(q.pop_front());
    end
    if (dok) begin
      if (q.size() == 0) chk({n, " stale data_ok"}, dok, 0);
      else begin
        chk({n, " data_ok cycle"}, cyc, q[0].c);
        chk({n, " rdata"}, rd, q[0].d);
        void'(q.pop_front());
      end
    end else chk({n, " idle rdata"}, rd, 0);
  endtask
  always @(negedge clk) begin
    mon("L2", dok2, rd2, q2);
    mon("L4", dok4, rd4, q4);
  end
  task automatic op(input logic w, input logic [3:0] s, input logic [31:0] a, input logic [31:0] d,
                    input logic [31:0] e, input logic [1:0] sz = 2'd2);
    req = 1; wr = w; wstrb = s; addr = a; wdata = d; size = sz;
    @(negedge clk);
    chk("L2 addr_ok", ok2, 1);
    chk("L4 addr_ok", ok4, 1);
    q2.push_back('{e, cyc + 2});
    q4.push_back('{e, cyc + 4});
    @(posedge clk); #1;
  endtask
  task automatic idle(input int n);
    req = 0; wr = 0; wstrb = 0; size = 2'd2;
    repeat (n) @(posedge clk);
    #1;
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    repeat (2) @(posedge clk);
    #1 reset = 0;
    @(negedge clk);
    chk("reset L2 addr_ok", ok2, 1);
    chk("reset L4 addr_ok", ok4, 1);
    chk("reset L2 data_ok", dok2, 0);
    chk("reset L4 data_ok", dok4, 0);
    @(posedge clk); #1;
    op(1, 4'hF, 32'h40, 32'hA1B2C3D4, 0);
    op(1, 4'hF, 32'h20, 32'hFFFFFFFF, 0);
    idle(6);
    op(0, 4'h0, 32'h40, 0, 32'hA1B2C3D4);
    idle(6);
    op(1, 4'h5, 32'h20, 32'h11223344, 0);
    op(0, 4'h0, 32'h20, 0, 32'hFF22FF44);
    idle(6);
    for (int i = 0; i < 8; i++) op(1, 4'hF, 32'h100 + 4 * i, 32'hC0DE0000 + i, 0);
    for (int i = 0; i < 8; i++) op(0, 4'h0, 32'h100 + 4 * i, 0, 32'hC0DE0000 + i);
    idle(8);
    req = 1; wr = 0; addr = 32'h40; addr_block = 1;
    repeat (3) begin
      @(negedge clk);
      chk("blocked L2 addr_ok", ok2, 0);
      chk("blocked L4 addr_ok", ok4, 0);
      @(posedge clk); #1;
    end
    addr_block = 0;
    op(0, 4'h0, 32'h40, 0, 32'hA1B2C3D4);
    idle(6);
    for (int i = 0; i < 3; i++) op(0, 4'h0, 32'h40, 0, 32'hA1B2C3D4);
    req = 0; reset = 1;
    @(posedge clk); #1;
    reset = 0;
    q2.delete();
    q4.delete();
    @(negedge clk);
    chk("post-reset L2 data_ok", dok2, 0);
    chk("post-reset L4 data_ok", dok4, 0);
    chk("post-reset L2 addr_ok", ok2, 1);
    chk("post-reset L4 addr_ok", ok4, 1);
    @(posedge clk); #1;
    idle(8);
    op(0, 4'h0, 32'h1040, 0, 32'hA1B2C3D4);
    op(0, 4'h0, 32'h43, 0, 32'hA1B2C3D4, 2'd0);
    idle(8);
    chk("L2 queue drained", q2.size(), 0);
    chk("L4 queue drained", q4.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
